// File: rtl/mac_share_arbiter_if.sv
// MAC-side bus of mac_share_arbiter: start pulse and operands out, result pulse and value back.
interface mac_share_arbiter_if #(
    parameter int SIZE  = 8,
    parameter int SETS  = 4,
    parameter int OUT_W = 2 * SIZE
);
    logic                      mac_valid;
    logic [SETS-1:0][SIZE-1:0] mac_a;
    logic [SETS-1:0][SIZE-1:0] mac_b;
    logic                      mac_ready;
    logic [OUT_W-1:0]          mac_out;

    modport master (
        output mac_valid, mac_a, mac_b,
        input  mac_ready, mac_out
    );

    modport slave (
        input  mac_valid, mac_a, mac_b,
        output mac_ready, mac_out
    );
endinterface

// File: rtl/mac_share_arbiter.sv
// Round-robin arbiter sharing one unary_binary_MAC among NREQ requesters.
// Define MAC_ARB_TIMEOUT_EN to add a watchdog on the wait for the MAC result.
module mac_share_arbiter #(
    parameter int  NREQ    = 4,
    parameter int  SIZE    = 8,
    parameter int  SETS    = 4,
    parameter int  OUT_W   = 2 * SIZE,
    parameter int  TIMEOUT = 64,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NREQ-1:0]                     req,
    input  logic [NREQ-1:0][SETS-1:0][SIZE-1:0] req_a,
    input  logic [NREQ-1:0][SETS-1:0][SIZE-1:0] req_b,
    mac_share_arbiter_if.master                 mac,
    output logic [NREQ-1:0]                     resp_valid,
    output logic [OUT_W-1:0]                    resp_data,
    output logic                                resp_err,
    output logic                                busy,
    output logic [IDW-1:0]                      grant_id
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mac_share_arbiter: TIMEOUT must be at least 1");
    end

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] winner;
    logic           found;

`ifdef MAC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
`endif

    // First active requester at or above ptr, wrapping to 0.
    always_comb begin : pick
        int unsigned idx;
        idx    = 0;
        winner = ptr;
        found  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr) + i) % 32'(NREQ);
            if (!found && req[idx[IDW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_id  <= '0;
            resp_data <= '0;
            mac.mac_a <= '0;
            mac.mac_b <= '0;
`ifdef MAC_ARB_TIMEOUT_EN
            cnt       <= '0;
            resp_err  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        mac.mac_a <= req_a[winner];
                        mac.mac_b <= req_b[winner];
                        grant_id  <= winner;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef MAC_ARB_TIMEOUT_EN
                    cnt   <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (mac.mac_ready) begin
                        resp_data <= mac.mac_out;
`ifdef MAC_ARB_TIMEOUT_EN
                        resp_err  <= 1'b0;
`endif
                        state     <= RESP;
                    end
`ifdef MAC_ARB_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT - 1)) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    ptr   <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef MAC_ARB_TIMEOUT_EN
    assign resp_err = 1'b0;
`endif

    assign mac.mac_valid = (state == ISSUE);
    assign busy          = (state != IDLE);

    always_comb begin
        resp_valid = '0;
        if (state == RESP) resp_valid[grant_id] = 1'b1;
    end

endmodule
